encdec_mac_accum: RTL



---
 rtl/encdec_mac_accum.sv | 117 +++++++++++
 1 files changed

// File: rtl/encdec_mac_accum.sv
// Frame accumulator for the encdec multiplier stream: sums FRAME_LEN products, one result per frame.
// Define ENCDEC_ACC_SAT_EN to saturate the sum to all-ones on overflow instead of wrapping.
module encdec_mac_accum #(
    parameter int PROD_W    = 32,
    parameter int ACC_W     = 40,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [PROD_W-1:0] prod_dat,
    input  logic              prod_vld,
    output logic              prod_rdy,
    input  logic              clr,
    output logic [ACC_W-1:0]  acc_dat,
    output logic              acc_vld,
    input  logic              acc_rdy,
    output logic              acc_ovf
);

    if (FRAME_LEN < 1 || FRAME_LEN > (1 << CNT_W) || ACC_W < PROD_W) begin : g_param_err
        $error("encdec_mac_accum: illegal FRAME_LEN/CNT_W/ACC_W combination");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   dat_q, dat_d;
    logic               vld_q, vld_d;
    logic               aovf_q, aovf_d;

    logic [ACC_W:0]     sum;
    logic               carry;
    logic [ACC_W-1:0]   sum_val;

    assign sum   = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_dat};
    assign carry = sum[ACC_W];

`ifdef ENCDEC_ACC_SAT_EN
    // Once the frame has overflowed, the running sum is pinned at all-ones.
    assign sum_val = (ovf_q | carry) ? '1 : sum[ACC_W-1:0];
`else
    assign sum_val = sum[ACC_W-1:0];
`endif

    assign prod_rdy = (state_q == ACCUM) & ~clr;
    assign acc_dat  = dat_q;
    assign acc_vld  = vld_q;
    assign acc_ovf  = aovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        dat_d   = dat_q;
        vld_d   = vld_q;
        aovf_d  = aovf_q;
        case (state_q)
            ACCUM: begin
                if (clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (prod_vld) begin
                    if (cnt_q == LAST) begin
                        dat_d   = sum_val;
                        aovf_d  = ovf_q | carry;
                        vld_d   = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        acc_d = sum_val;
                        cnt_d = cnt_q + CNT_W'(1);
                        ovf_d = ovf_q | carry;
                    end
                end
            end
            HOLD: begin
                // clr is deliberately ignored here so a finished result is never lost.
                if (acc_rdy) begin
                    vld_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            aovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            aovf_q  <= aovf_d;
        end
    end

endmodule
